// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame shift
// on device clock falling edges, ACK check and bus-idle wait, with timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       tx_busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_clkSync;
  logic [1:0]       r_datSync;
  logic             r_clkFilt;
  logic             r_clkFiltD;
  logic [FLT_W-1:0] r_fltCnt;
  logic [9:0]       r_frame;
  logic [3:0]       r_bitCnt;
  logic [INH_W-1:0] r_inhCnt;
  logic [TO_W-1:0]  r_toCnt;
  logic             r_clkOe;
  logic             r_datOe;
  logic             r_done;
  logic             r_error;
  logic             r_ready;
  logic             r_busy;

  logic w_fall;
  logic w_timeout;

  assign w_fall    = r_clkFiltD & ~r_clkFilt;
  assign w_timeout = (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));

  // The filtered clock only follows the line after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clkSync  <= 2'b11;
      r_datSync  <= 2'b11;
      r_clkFilt  <= 1'b1;
      r_clkFiltD <= 1'b1;
      r_fltCnt   <= '0;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk_in};
      r_datSync  <= {r_datSync[0], ps2_dat_in};
      r_clkFiltD <= r_clkFilt;
      if (r_clkSync[1] == r_clkFilt) begin
        r_fltCnt <= '0;
      end else if (r_fltCnt == FLT_W'(FILTER_LEN - 1)) begin
        r_clkFilt <= r_clkSync[1];
        r_fltCnt  <= '0;
      end else begin
        r_fltCnt <= r_fltCnt + 1'b1;
      end
    end
  end

  // Ready/busy lag the return to IDLE by one cycle so a done/error pulse never overlaps ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_frame  <= '0;
      r_bitCnt <= '0;
      r_inhCnt <= '0;
      r_toCnt  <= '0;
      r_clkOe  <= 1'b0;
      r_datOe  <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_clkOe <= 1'b0;
          r_datOe <= 1'b0;
          if (tx_valid && r_ready) begin
            r_frame  <= {1'b1, ~^tx_data, tx_data};
            r_inhCnt <= '0;
            r_clkOe  <= 1'b1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_inhCnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            r_datOe <= 1'b1;
            r_state <= RTS;
          end else begin
            r_inhCnt <= r_inhCnt + 1'b1;
          end
        end
        RTS: begin
          r_clkOe  <= 1'b0;
          r_bitCnt <= '0;
          r_toCnt  <= '0;
          r_state  <= SEND;
        end
        SEND: begin
          if (w_timeout) begin
            r_clkOe <= 1'b0;
            r_datOe <= 1'b0;
            r_error <= 1'b1;
            r_state <= IDLE;
          end else if (w_fall) begin
            r_datOe  <= ~r_frame[r_bitCnt];
            r_bitCnt <= r_bitCnt + 1'b1;
            r_toCnt  <= '0;
            if (r_bitCnt == 4'd9)
              r_state <= ACK;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        ACK: begin
          if (w_timeout) begin
            r_clkOe <= 1'b0;
            r_datOe <= 1'b0;
            r_error <= 1'b1;
            r_state <= IDLE;
          end else if (w_fall) begin
            r_toCnt <= '0;
            if (r_datSync[1]) begin
              r_error <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= WAIT_IDLE;
            end
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (w_timeout) begin
            r_clkOe <= 1'b0;
            r_datOe <= 1'b0;
            r_error <= 1'b1;
            r_state <= IDLE;
          end else if (r_clkFilt && r_datSync[1]) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (w_fall) begin
            r_toCnt <= '0;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_ready   = r_ready;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign tx_error   = r_error;
  assign ps2_clk_oe = r_clkOe;
  assign ps2_dat_oe = r_datOe;

endmodule
